system_switch_pio_irq: RTL and testbench



---
 rtl/system_pio_pkg.sv | 27 ++
 rtl/system_pio_debounce.sv | 85 ++++++++
 rtl/system_switch_pio_irq.sv | 130 +++++++++++++
 tb/tb_system_switch_pio_irq.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/system_pio_pkg.sv
// -----------------------------------------------------------------------------
// system_pio_pkg
// Shared constants for the switch-bank PIO: Avalon word addresses of the
// register map, edge-select encodings, and a helper that sizes the debounce
// counter.
// -----------------------------------------------------------------------------
package system_pio_pkg;

    // Register map (word addresses)
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    // Edge that sets an edgecapture bit
    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // clog2(cycles+1), never below 1 so the counter declaration stays legal.
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/system_pio_debounce.sv
// -----------------------------------------------------------------------------
// system_pio_debounce
// One input bit: SYNC_STAGES-deep synchroniser followed by an optional
// debounce filter. With DEBOUNCE_CYCLES==0 the filter collapses to a single
// register that follows the synchronised input.
//
// Ports:
//   clk       in   system clock
//   reset_n   in   asynchronous active-low reset
//   din_i     in   raw asynchronous switch input
//   stable_o  out  debounced value (resets to 0)
// -----------------------------------------------------------------------------
module system_pio_debounce
    import system_pio_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din_i,
    output logic stable_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_in;
    logic                   stable_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
        end
    end

    assign sync_in = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    stable_q <= 1'b0;
                end else begin
                    stable_q <= sync_in;
                end
            end
        end else begin : g_debounce
            localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
            localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;
            logic          stable_d;

            // The counter runs only while the input disagrees with the
            // accepted value; on the DEBOUNCE_CYCLES-th disagreeing cycle the
            // new value is accepted and the counter restarts, so it never wraps.
            always_comb begin
                cnt_d    = '0;
                stable_d = stable_q;
                if (sync_in != stable_q) begin
                    if (cnt_q == CNT_LAST) begin
                        stable_d = sync_in;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q    <= '0;
                    stable_q <= 1'b0;
                end else begin
                    cnt_q    <= cnt_d;
                    stable_q <= stable_d;
                end
            end
        end
    endgenerate

    assign stable_o = stable_q;

endmodule

// File: rtl/system_switch_pio_irq.sv
// -----------------------------------------------------------------------------
// system_switch_pio_irq
// Input PIO for the board switch/key bank on the Avalon-MM peripheral bus.
// Each bit is synchronised and optionally debounced; selected edges of the
// debounced value are latched in edgecapture, and a level interrupt is raised
// while any captured edge is also enabled in irqmask.
//
// Bus handshake: no waitrequest, no read strobe. Every cycle readdata is
// registered from the register addressed in that cycle, so data for the
// address presented in cycle N is valid in cycle N+1. A write is accepted in
// any cycle write_n is low. Reads have no side effects.
//
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   address    in   word address (0 data, 1 reserved, 2 irqmask, 3 edgecapture)
//   write_n    in   active-low write strobe
//   writedata  in   write data (low WIDTH bits used)
//   in_port    in   asynchronous switch inputs
//   readdata   out  registered read data, zero-extended
//   irq        out  level interrupt, active high
// -----------------------------------------------------------------------------
module system_switch_pio_irq
    import system_pio_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 0,
    parameter int               EDGE_TYPE       = 0,
    parameter logic [WIDTH-1:0] IRQ_MASK_RESET  = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] edgecap_q,  edgecap_d;
    logic [WIDTH-1:0] irqmask_q,  irqmask_d;
    logic [WIDTH-1:0] rd_field;
    logic [31:0]      readdata_q, readdata_d;
    logic             wr_en;
    logic             unused_wdata;

    // Bits above WIDTH carry no state.
    assign unused_wdata = ^writedata;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            system_pio_debounce #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk      (clk),
                .reset_n  (reset_n),
                .din_i    (in_port[i]),
                .stable_o (stable[i])
            );
        end
    endgenerate

    assign wr_en = !write_n;

    always_comb begin
        rise = stable & ~prev_q;
        fall = ~stable & prev_q;
        case (EDGE_TYPE)
            EDGE_FALLING: edges = fall;
            EDGE_ANY:     edges = rise | fall;
            default:      edges = rise;
        endcase
    end

    // Clear is applied first and the new edge ORed in after, so an edge that
    // lands in the same cycle as its W1C is kept.
    always_comb begin
        clr = '0;
        if (wr_en && (address == ADDR_EDGECAP)) begin
            clr = writedata[WIDTH-1:0];
        end
        edgecap_d = (edgecap_q & ~clr) | edges;

        irqmask_d = irqmask_q;
        if (wr_en && (address == ADDR_IRQMASK)) begin
            irqmask_d = writedata[WIDTH-1:0];
        end
    end

    always_comb begin
        rd_field = '0;
        case (address)
            ADDR_DATA:    rd_field = stable;
            ADDR_IRQMASK: rd_field = irqmask_q;
            ADDR_EDGECAP: rd_field = edgecap_q;
            default:      rd_field = '0;
        endcase
        readdata_d              = '0;
        readdata_d[WIDTH-1:0]   = rd_field;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= '0;
            edgecap_q  <= '0;
            irqmask_q  <= IRQ_MASK_RESET;
            readdata_q <= '0;
        end else begin
            prev_q     <= stable;
            edgecap_q  <= edgecap_d;
            irqmask_q  <= irqmask_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    // Straight from registers: follows edgecapture/irqmask with no added delay
    // and drops as soon as reset clears them.
    assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_system_switch_pio_irq.sv
// -----------------------------------------------------------------------------
// tb_system_switch_pio_irq
// Three instances share one bus: A (WIDTH=4, no debounce, rising edges),
// B (WIDTH=4, DEBOUNCE_CYCLES=8), C (WIDTH=32, any edge, irqmask reset 5).
// Drivers issue requests at the falling edge and push expected values; the
// monitor compares one cycle later, after the DUT's registered response.
// -----------------------------------------------------------------------------
module tb_system_switch_pio_irq;
    import system_pio_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [1:0]  address;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_a, in_b;
    logic [31:0] in_c;
    logic [31:0] rd_a, rd_b, rd_c;
    logic        irq_a, irq_b, irq_c;

    system_switch_pio_irq #(
        .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0), .IRQ_MASK_RESET(4'h0)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .write_n(write_n),
        .writedata(writedata), .in_port(in_a), .readdata(rd_a), .irq(irq_a)
    );

    system_switch_pio_irq #(
        .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .EDGE_TYPE(0), .IRQ_MASK_RESET(4'h0)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .address(address), .write_n(write_n),
        .writedata(writedata), .in_port(in_b), .readdata(rd_b), .irq(irq_b)
    );

    system_switch_pio_irq #(
        .WIDTH(32), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2), .IRQ_MASK_RESET(32'h5)
    ) dut_c (
        .clk(clk), .reset_n(reset_n), .address(address), .write_n(write_n),
        .writedata(writedata), .in_port(in_c), .readdata(rd_c), .irq(irq_c)
    );

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic [0:0]  exp_irq_q[$];
    string       irq_name_q[$];

    logic rd_valid, irq_valid, rd_valid_q, irq_valid_q;
    int   rd_sel, irq_sel, rd_sel_q, irq_sel_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pick_rd(input int sel);
        case (sel)
            0:       return rd_a;
            1:       return rd_b;
            default: return rd_c;
        endcase
    endfunction

    function automatic logic pick_irq(input int sel);
        case (sel)
            0:       return irq_a;
            1:       return irq_b;
            default: return irq_c;
        endcase
    endfunction

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        rd_valid_q  <= rd_valid;
        rd_sel_q    <= rd_sel;
        irq_valid_q <= irq_valid;
        irq_sel_q   <= irq_sel;
    end

    logic [31:0] mon_exp;
    logic [0:0]  mon_irq_exp;
    string       mon_name;

    always @(negedge clk) begin
        if (rd_valid_q === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rd_underflow: got response, expected none queued");
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                check(mon_name, pick_rd(rd_sel_q), mon_exp);
            end
        end
        if (irq_valid_q === 1'b1) begin
            if (exp_irq_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL irq_underflow: got sample, expected none queued");
            end else begin
                mon_irq_exp = exp_irq_q.pop_front();
                mon_name    = irq_name_q.pop_front();
                check(mon_name, {31'b0, pick_irq(irq_sel_q)}, {31'b0, mon_irq_exp});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue_rd(input int sel, input logic [1:0] addr, input logic [31:0] exp,
                            input string name);
        address  = addr;
        rd_valid = 1'b1;
        rd_sel   = sel;
        exp_q.push_back(exp);
        name_q.push_back(name);
    endtask

    task automatic issue_wr(input logic [1:0] addr, input logic [31:0] data);
        address   = addr;
        writedata = data;
        write_n   = 1'b0;
    endtask

    task automatic issue_irq(input int sel, input logic exp, input string name);
        irq_valid = 1'b1;
        irq_sel   = sel;
        exp_irq_q.push_back(exp);
        irq_name_q.push_back(name);
    endtask

    task automatic step();
        @(negedge clk);
        rd_valid  = 1'b0;
        irq_valid = 1'b0;
        write_n   = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic rd(input int sel, input logic [1:0] addr, input logic [31:0] exp,
                      input string name);
        issue_rd(sel, addr, exp, name);
        step();
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        issue_wr(addr, data);
        step();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        reset_n   = 1'b0;
        address   = ADDR_DATA;
        write_n   = 1'b1;
        writedata = '0;
        in_a      = '0;
        in_b      = '0;
        in_c      = '0;
        rd_valid  = 1'b0;
        irq_valid = 1'b0;
        rd_sel    = 0;
        irq_sel   = 0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // reset values
        rd(0, ADDR_DATA,    32'h0, "a_reset_data");
        rd(0, ADDR_IRQMASK, 32'h0, "a_reset_mask");
        rd(0, ADDR_EDGECAP, 32'h0, "a_reset_edgecap");
        rd(2, ADDR_IRQMASK, 32'h5, "c_reset_mask");
        issue_irq(0, 1'b0, "a_reset_irq");
        step();

        // data path latency: first valid read SYNC_STAGES+2 cycles after change
        in_a = 4'b1010;
        for (int k = 0; k < 5; k++) begin
            rd(0, ADDR_DATA, (k < 3) ? 32'h0 : 32'hA, "a_data_latency");
        end
        rd(0, ADDR_RSVD,    32'h0, "a_rsvd");
        rd(0, ADDR_EDGECAP, 32'hA, "a_edgecap_rise");

        // read-only and reserved writes are ignored
        wr(ADDR_RSVD, 32'hFFFF_FFFF);
        wr(ADDR_DATA, 32'hFFFF_FFFF);
        rd(0, ADDR_DATA, 32'hA, "a_data_after_ro_write");
        rd(0, ADDR_RSVD, 32'h0, "a_rsvd_after_write");

        // partial W1C
        wr(ADDR_EDGECAP, 32'h2);
        rd(0, ADDR_EDGECAP, 32'h8, "a_w1c_partial");
        wr(ADDR_EDGECAP, 32'hF);

        // irqmask width limit
        wr(ADDR_IRQMASK, 32'hFFFF_FFFF);
        rd(0, ADDR_IRQMASK, 32'hF, "a_mask_width");
        wr(ADDR_IRQMASK, 32'h4);
        rd(0, ADDR_IRQMASK, 32'h4, "a_mask_write");
        issue_irq(0, 1'b0, "a_irq_idle");
        step();

        // interrupt on rising edge of bit2
        in_a = 4'b1110;
        idle(2);
        issue_irq(0, 1'b0, "a_irq_before_edge");
        step();
        issue_irq(0, 1'b1, "a_irq_rise");
        step();
        rd(0, ADDR_EDGECAP, 32'h4, "a_edgecap_bit2");
        issue_wr(ADDR_EDGECAP, 32'h4);
        issue_irq(0, 1'b0, "a_irq_after_w1c");
        step();
        rd(0, ADDR_EDGECAP, 32'h0, "a_edgecap_cleared");

        // falling edge is not captured
        in_a = 4'b1010;
        idle(6);
        rd(0, ADDR_EDGECAP, 32'h0, "a_no_fall_capture");
        issue_irq(0, 1'b0, "a_irq_no_fall");
        step();

        // W1C colliding with a new rising edge on bit1
        in_a = 4'b1000;
        idle(6);
        wr(ADDR_IRQMASK, 32'h2);
        wr(ADDR_EDGECAP, 32'hF);
        in_a = 4'b1010;
        idle(3);
        issue_wr(ADDR_EDGECAP, 32'h2);
        issue_irq(0, 1'b1, "a_irq_collision");
        step();
        rd(0, ADDR_EDGECAP, 32'h2, "a_edgecap_collision");

        // mask clear drops irq, edge stays pending
        issue_wr(ADDR_IRQMASK, 32'h0);
        issue_irq(0, 1'b0, "a_irq_mask_clear");
        step();
        rd(0, ADDR_EDGECAP, 32'h2, "a_edgecap_masked_pending");
        wr(ADDR_EDGECAP, 32'hF);

        // debounce: 5- and 7-cycle glitches rejected
        in_b = 4'b0001;
        idle(5);
        in_b = 4'b0000;
        idle(12);
        rd(1, ADDR_DATA,    32'h0, "b_glitch5_data");
        rd(1, ADDR_EDGECAP, 32'h0, "b_glitch5_edgecap");
        in_b = 4'b0001;
        idle(7);
        in_b = 4'b0000;
        idle(12);
        rd(1, ADDR_DATA,    32'h0, "b_glitch7_data");
        rd(1, ADDR_EDGECAP, 32'h0, "b_glitch7_edgecap");

        // debounce: 8 stable cycles accepted, exact cycle
        in_b = 4'b0001;
        idle(9);
        rd(1, ADDR_DATA, 32'h0, "b_stable_not_yet");
        rd(1, ADDR_DATA, 32'h1, "b_stable8_data");
        idle(2);
        rd(1, ADDR_EDGECAP, 32'h1, "b_stable8_edgecap");

        // WIDTH=32, any-edge capture on bit31
        in_c = 32'h8000_0000;
        idle(4);
        rd(2, ADDR_DATA,    32'h8000_0000, "c_data_bit31");
        rd(2, ADDR_EDGECAP, 32'h8000_0000, "c_edgecap_rise31");
        issue_irq(2, 1'b0, "c_irq_masked");
        step();
        wr(ADDR_EDGECAP, 32'h8000_0000);
        rd(2, ADDR_EDGECAP, 32'h0, "c_edgecap_cleared");
        in_c = 32'h0;
        idle(4);
        rd(2, ADDR_DATA,    32'h0,         "c_data_low");
        rd(2, ADDR_EDGECAP, 32'h8000_0000, "c_edgecap_fall31");
        issue_wr(ADDR_IRQMASK, 32'h8000_0000);
        issue_irq(2, 1'b1, "c_irq_unmasked");
        step();
        wr(ADDR_EDGECAP, 32'hFFFF_FFFF);

        // asynchronous reset with a pending interrupt
        wr(ADDR_IRQMASK, 32'hF);
        in_a = 4'b1011;
        idle(6);
        issue_irq(0, 1'b1, "a_irq_pre_reset");
        issue_rd(0, ADDR_EDGECAP, 32'h1, "a_edgecap_pre_reset");
        step();
        #2;
        reset_n = 1'b0;
        #1;
        check("a_async_reset_readdata", rd_a, 32'h0);
        check("a_async_reset_irq", {31'b0, irq_a}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(0, ADDR_EDGECAP, 32'h0, "a_edgecap_post_reset");
        rd(0, ADDR_IRQMASK, 32'h0, "a_mask_post_reset");
        rd(2, ADDR_IRQMASK, 32'h5, "c_mask_post_reset");
        idle(3);
        rd(0, ADDR_EDGECAP, 32'hB, "a_edge_after_reset");

        idle(2);
        check("scoreboard_drain", exp_q.size() + exp_irq_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
